vector_accumulator: RTL

//  Sequential reduction stage that sums a stream of NUM_TERMS fp32 vectors element-wise.
//  It sits between a producer of partial-product vectors (matrix tiles, per-batch

---
 rtl/vector_accumulator_pkg.sv | 118 +++++++++++
 rtl/vector_accumulator_vadd.sv | 17 +
 rtl/vector_accumulator.sv | 101 ++++++++++
 3 files changed

// File: rtl/vector_accumulator_pkg.sv
// Shared definitions for the vector accumulator: FSM encoding, fp32 constants
// and the scalar fp32 adder used by every lane of the vector datapath.
package vector_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    // IEEE-754 single-precision add, round-to-nearest-even, gradual underflow.
    // Any NaN operand, or inf - inf, yields the canonical quiet NaN.
    function automatic logic [31:0] fp32_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [7:0]  d;
        logic [26:0] mx;
        logic [26:0] my;
        logic [26:0] sh;
        logic [27:0] s;
        logic        stk;
        logic        rnd;
        logic [9:0]  e;
        logic [24:0] m;
        logic [31:0] r;

        x   = a;
        y   = b;
        ex  = 8'd0;
        ey  = 8'd0;
        d   = 8'd0;
        mx  = '0;
        my  = '0;
        sh  = '0;
        s   = '0;
        stk = 1'b0;
        rnd = 1'b0;
        e   = '0;
        m   = '0;
        r   = FP32_ZERO;

        if (a[30:0] > 31'h7F80_0000 || b[30:0] > 31'h7F80_0000) begin
            r = FP32_QNAN;
        end else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) begin
            r = (a[31] != b[31]) ? FP32_QNAN : a;
        end else if (a[30:23] == 8'hFF) begin
            r = a;
        end else if (b[30:23] == 8'hFF) begin
            r = b;
        end else begin
            // x is the larger magnitude; its sign decides the result sign
            if (b[30:0] > a[30:0]) begin
                x = b;
                y = a;
            end
            ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
            ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
            mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
            my = {y[30:23] != 8'd0, y[22:0], 3'b000};
            d  = ex - ey;

            // align smaller operand; shifted-out bits fold into a sticky LSB
            if (d > 8'd26) begin
                sh  = '0;
                stk = |my;
            end else begin
                sh  = my >> d;
                stk = |(my & ~({27{1'b1}} << d));
            end
            sh[0] = sh[0] | stk;

            if (x[31] == y[31]) begin
                s = {1'b0, mx} + {1'b0, sh};
            end else begin
                s = {1'b0, mx} - {1'b0, sh};
            end
            e = {2'b00, ex};

            if (s == 28'd0) begin
                // exact cancellation is +0 unless both inputs are -0
                r = {x[31] & y[31], 31'd0};
            end else begin
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 10'd1;
                end
                for (int i = 0; i < 26; i++) begin
                    if (!s[26] && e > 10'd1) begin
                        s = s << 1;
                        e = e - 10'd1;
                    end
                end
                rnd = s[2] & (s[1] | s[0] | s[3]);
                m   = {1'b0, s[26:3]} + {24'd0, rnd};
                if (m[24]) begin
                    m = m >> 1;
                    e = e + 10'd1;
                end
                if (e >= 10'd255) begin
                    r = {x[31], 8'hFF, 23'd0};
                end else begin
                    // m[23]==0 here means the result stayed subnormal
                    r = {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_accumulator_vadd.sv
// Combinational element-wise fp32 vector adder; lanes are fully independent.
// Ports: a, b - packed fp32 vectors (lane i at [32*i+:32]); sum - a + b per lane.
module vector_addition
    import vector_accumulator_pkg::*;
#(
    parameter int VLEN = 1
) (
    input  logic [32*VLEN-1:0] a,
    input  logic [32*VLEN-1:0] b,
    output logic [32*VLEN-1:0] sum
);

    for (genvar g = 0; g < VLEN; g++) begin : g_lane
        assign sum[32*g +: 32] = fp32_add(a[32*g +: 32], b[32*g +: 32]);
    end

endmodule

// File: rtl/vector_accumulator.sv
// Sums NUM_TERMS fp32 vectors element-wise and hands the result downstream.
// Ports:
//   clk, rst_n (sync, active-low), clear (sync abort of the current sum)
//   in_valid/in_ready/in_data    - producer side, one vector per beat
//   out_valid/out_ready/out_data - consumer side, registered sum
//   busy                         - a sum is in progress or waiting to drain
module vector_accumulator
    import vector_accumulator_pkg::*;
#(
    parameter int VLEN      = 1,
    parameter int NUM_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*VLEN-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*VLEN-1:0] out_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);
    localparam logic [32*VLEN-1:0] ACC_ZERO = {VLEN{FP32_ZERO}};

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [32*VLEN-1:0] acc;
    logic [32*VLEN-1:0] acc_nx;
    logic [32*VLEN-1:0] sum;
    logic              accept;

    vector_addition #(
        .VLEN(VLEN)
    ) u_vadd (
        .a  (acc),
        .b  (in_data),
        .sum(sum)
    );

    assign in_ready  = (state != DONE) && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign busy      = (state == ACCUM) || (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= ACC_ZERO;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        if (clear) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            acc_nx   = ACC_ZERO;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_nx = sum;
                        if (cnt == LAST) begin
                            state_nx = DONE;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = ACCUM;
                            cnt_nx   = cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                        acc_nx   = ACC_ZERO;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    acc_nx   = ACC_ZERO;
                end
            endcase
        end
    end

endmodule
